// File: rtl/addsub_chunk_seq.sv
// Sequential adder/subtractor: adds CHUNK bits per cycle, WIDTH/CHUNK cycles per result.
// Define ADDSUB_CHUNK_SAT_EN to clamp overflowing results to the signed limit.
module addsub_chunk_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             over_flow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_sel;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_zero;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK:0]   w_cs;
    logic             w_msb_cin;
    logic             w_ovf;
    logic [WIDTH-1:0] w_full;
    logic [WIDTH-1:0] w_final;

    assign w_base = 32'(r_idx) * CHUNK;
    assign w_ca   = r_a[w_base +: CHUNK];
    assign w_cb   = r_b[w_base +: CHUNK];
    assign w_cs   = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_carry};

    // Carry into a bit is recovered from its operand and sum bits; only used on the last chunk.
    assign w_msb_cin = w_ca[CHUNK-1] ^ w_cb[CHUNK-1] ^ w_cs[CHUNK-1];
    assign w_ovf     = w_msb_cin ^ w_cs[CHUNK];

    always_comb begin
        w_full = r_acc;
        w_full[w_base +: CHUNK] = w_cs[CHUNK-1:0];
    end

`ifdef ADDSUB_CHUNK_SAT_EN
    always_comb begin
        w_final = w_full;
        if (w_ovf) begin
            w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_final = w_full;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_sel       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b ^ {WIDTH{sel}};
                        r_carry    <= c_in;
                        r_sel      <= sel;
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_full;
                    r_carry <= w_cs[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_sum       <= w_final;
                        r_c_out     <= w_cs[CHUNK] ^ r_sel;
                        r_ovf       <= w_ovf;
                        r_zero      <= (w_final == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // New operands are only taken on a later cycle, back in IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_zero      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign over_flow = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_chunk_seq.sv
// Scoreboard bench for addsub_chunk_seq: a 16/4 instance and an 8/8 single-chunk instance.
module tb_addsub_chunk_seq;

    typedef struct packed {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
    } exp16_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       c_out;
        logic       ovf;
        logic       zero;
    } exp8_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        c_in, sel, c_out, over_flow, zero;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, sum8;
    logic        c_in8, sel8, c_out8, over_flow8, zero8;

    int checks = 0;
    int errors = 0;
    exp16_t sb_q[$];
    exp8_t  sb8_q[$];

    always #5 clk = ~clk;

    addsub_chunk_seq #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .over_flow(over_flow), .zero(zero)
    );

    addsub_chunk_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8), .sel(sel8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .c_out(c_out8), .over_flow(over_flow8), .zero(zero8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp16_t model16(input logic [15:0] ai, input logic [15:0] bi,
                                       input logic si, input logic ci);
        logic [15:0] bx;
        logic [16:0] full;
        exp16_t e;
        bx    = bi ^ {16{si}};
        full  = {1'b0, ai} + {1'b0, bx} + {16'd0, ci};
        e.sum = full[15:0];
        e.c_out = full[16] ^ si;
        e.ovf = (ai[15] == bx[15]) && (full[15] != ai[15]);
`ifdef ADDSUB_CHUNK_SAT_EN
        if (e.ovf) e.sum = ai[15] ? 16'h8000 : 16'h7FFF;
`endif
        e.zero = (e.sum == 16'h0000);
        return e;
    endfunction

    function automatic exp8_t model8(input logic [7:0] ai, input logic [7:0] bi,
                                     input logic si, input logic ci);
        logic [7:0] bx;
        logic [8:0] full;
        exp8_t e;
        bx    = bi ^ {8{si}};
        full  = {1'b0, ai} + {1'b0, bx} + {8'd0, ci};
        e.sum = full[7:0];
        e.c_out = full[8] ^ si;
        e.ovf = (ai[7] == bx[7]) && (full[7] != ai[7]);
`ifdef ADDSUB_CHUNK_SAT_EN
        if (e.ovf) e.sum = ai[7] ? 8'h80 : 8'h7F;
`endif
        e.zero = (e.sum == 8'h00);
        return e;
    endfunction

    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi,
                          input logic si, input logic ci, input int hold);
        int lat;
        exp16_t e;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = ai; b = bi; sel = si; c_in = ci; in_valid = 1'b1;
        sb_q.push_back(model16(ai, bi, si, ci));
        @(posedge clk); #1;
        // Scramble operands while the operation is running.
        in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        sel = 1'($urandom); c_in = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sum", 32'(sum), 32'(e.sum));
            chk("c_out", 32'(c_out), 32'(e.c_out));
            chk("over_flow", 32'(over_flow), 32'(e.ovf));
            chk("zero", 32'(zero), 32'(e.zero));
            chk("in_ready_done", 32'(in_ready), 32'd0);
            for (int i = 0; i < hold; i++) begin
                in_valid = ~in_valid; a = 16'($urandom); b = 16'($urandom);
                @(posedge clk); #1;
                chk("hold_sum", 32'(sum), 32'(e.sum));
                chk("hold_flags", {29'd0, c_out, over_flow, zero}, {29'd0, e.c_out, e.ovf, e.zero});
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        exp8_t e8;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sel = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sel8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", {29'd0, c_out, over_flow, zero}, 32'd0);
        chk("rst_in_ready8", 32'(in_ready8), 32'd1);
        rst_n = 1'b1;

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b1, 0);
        run_op(16'hA5C3, 16'h0F0F, 1'b0, 1'b1, 3);
        for (int i = 0; i < 4; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        // Reset at the second RUN cycle abandons the operation.
        a = 16'hFFFF; b = 16'h0001; sel = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("no_stale_result", 32'(seen), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0);

        // Single-chunk instance.
        chk("in_ready8", 32'(in_ready8), 32'd1);
        a8 = 8'h80; b8 = 8'h01; sel8 = 1'b1; c_in8 = 1'b1; in_valid8 = 1'b1;
        sb8_q.push_back(model8(8'h80, 8'h01, 1'b1, 1'b1));
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency8", 32'(lat), 32'd1);
        chk("sb8_nonempty", 32'(sb8_q.size() > 0), 32'd1);
        if (sb8_q.size() > 0) begin
            e8 = sb8_q.pop_front();
            chk("sum8", 32'(sum8), 32'(e8.sum));
            chk("flags8", {29'd0, c_out8, over_flow8, zero8}, {29'd0, e8.c_out, e8.ovf, e8.zero});
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("release8", 32'(out_valid8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_chunk_seq.md
ADDSUB_CHUNK_SEQ -- requirements
Module: addsub_chunk_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (>= 2).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK == 0 is required; N = WIDTH/CHUNK.
REQ-003 SHALL have one clock and a synchronous active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous reset, active low.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a, b  input  WIDTH  operands, two's complement.
REQ-009 c_in  input  1  carry into bit 0.
REQ-010 sel  input  1  0 = add, 1 = subtract (b inverted).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  MSB carry XOR sel (borrow flag when sel=1).
REQ-015 over_flow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-016 zero  output  1  high when sum == 0 while out_valid.

Function
REQ-017 Arithmetic SHALL be sum = a + (b XOR {WIDTH{sel}}) + c_in, mod 2^WIDTH; c_in is not forced by sel (caller drives c_in=1 for two's-complement subtract).
REQ-018 FSM SHALL have states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 IDLE: on in_valid & in_ready, a, b^sel, c_in, sel SHALL be registered, chunk index cleared, go to RUN; otherwise stay.
REQ-020 RUN: each cycle SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) with the registered running carry, write those sum bits, update carry, k++.
REQ-021 After chunk N-1 SHALL go to DONE; out_valid rises exactly N cycles after the accepting edge.
REQ-022 Carry into MSB and carry out of MSB SHALL be captured during chunk N-1 to form over_flow and c_out.
REQ-023 DONE: sum, c_out, over_flow, zero SHALL hold stable while out_ready = 0; on out_ready = 1 go to IDLE (no new accept in that same cycle).
REQ-024 Operand inputs SHALL be ignored outside IDLE; changes mid-RUN do not affect the result.
REQ-025 CHUNK == WIDTH SHALL give N = 1 (single RUN cycle).
REQ-026 in_valid and out_ready both high in DONE: only the output handshake completes.

Reset
REQ-027 rst_n = 0 at a rising edge SHALL force IDLE, in_ready = 1, out_valid = 0, sum = 0, c_out = 0, over_flow = 0, zero = 0, carry and index = 0.
REQ-028 Reset during RUN or DONE SHALL abandon the operation; no out_valid for it is ever produced.

Configuration
REQ-029 Macro ADDSUB_CHUNK_SAT_EN: when defined, if over_flow = 1 the sum presented in DONE SHALL be clamped to the signed limit (0111..1 if a's MSB is 0, 1000..0 if 1); c_out and over_flow still report the raw result; zero is evaluated on the clamped sum.
REQ-030 Without ADDSUB_CHUNK_SAT_EN, sum SHALL be the wrapped result of REQ-017 and no clamp logic exists.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 a=0x7FFF, b=0x0001, sel=0, c_in=0 -> out_valid 4 cycles after accept; sum=0x8000 (0x7FFF with SAT_EN), over_flow=1, c_out=0.
REQ-032 a=0x0005, b=0x0007, sel=1, c_in=1 -> sum=0xFFFE, c_out=1, over_flow=0, zero=0.
REQ-033 a=0xFFFF, b=0x0001, sel=0, c_in=0 -> sum=0x0000, c_out=1, over_flow=0, zero=1.
REQ-034 Hold out_ready=0 for 3 cycles in DONE, toggle a/b/in_valid -> outputs unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n=0 for one edge at RUN cycle 2 -> next cycle in_ready=1, out_valid=0, sum=0; no stale result later.
REQ-036 WIDTH=8, CHUNK=8: a=0x80, b=0x01, sel=1, c_in=1 -> out_valid 1 cycle after accept, sum=0x7F, over_flow=1, c_out=0.
